// File: rtl/nyq_pkg.sv
// nyq_pkg: widths and rounding constants shared by the NYQ filter and its decimator.
package nyq_pkg;

  localparam int NYQ_IN_W  = 24;
  localparam int NYQ_OUT_W = 16;

  function automatic int nyq_shift(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

  localparam int NYQ_S = nyq_shift(NYQ_IN_W, NYQ_OUT_W);

  localparam logic [NYQ_OUT_W-1:0] SAT_MAX = {1'b0, {(NYQ_OUT_W-1){1'b1}}};
  localparam logic [NYQ_OUT_W-1:0] SAT_MIN = {1'b1, {(NYQ_OUT_W-1){1'b0}}};

endpackage

// File: rtl/nyq_dec_fifo.sv
// nyq_dec_fifo: synchronous FIFO with combinational head read, fill count and synchronous clear.
module nyq_dec_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_fill
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push_ok, w_pop_ok;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_fill    = r_cnt;
  assign o_head    = r_mem[r_rptr];
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (w_push_ok && !i_clr) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/nyq_decim.sv
// nyq_decim: keeps every D-th NYQ sample, rounds it IN_WIDTH->OUT_WIDTH and queues it for framing.
// Build option NYQ_DEC_SAT_EN: saturate positive rounding overflow instead of wrapping.
module nyq_decim
  import nyq_pkg::*;
#(
  parameter int IN_WIDTH   = NYQ_IN_W,
  parameter int OUT_WIDTH  = NYQ_OUT_W,
  parameter int DEC_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RI,
  input  logic                          Clr_SI,
  input  logic [DEC_WIDTH-1:0]          Dec_DI,
  input  logic [IN_WIDTH-1:0]           NYQ_In_DI,
  input  logic                          NYQ_Vld_SI,
  output logic [OUT_WIDTH-1:0]          Dec_Out_DO,
  output logic                          Dec_Vld_SO,
  input  logic                          Dec_Rdy_SI,
  output logic [$clog2(FIFO_DEPTH):0]   Fill_DO,
  output logic                          Ovf_SO
);

  localparam int S = nyq_shift(IN_WIDTH, OUT_WIDTH);
  localparam logic [IN_WIDTH:0]    L_HALF    = (IN_WIDTH+1)'(1) << (S-1);
  localparam logic [OUT_WIDTH-1:0] L_SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic [DEC_WIDTH-1:0] r_phase, w_dec_m1;
  logic                 w_keep;
  logic [IN_WIDTH:0]    w_sum;
  logic [OUT_WIDTH:0]   w_shr;
  logic [OUT_WIDTH-1:0] w_rnd;
  logic                 w_unused;
  logic                 r_s1_vld;
  logic [OUT_WIDTH-1:0] r_s1_dat;
  logic [OUT_WIDTH-1:0] w_head, r_hold;
  logic                 w_full, w_empty, w_pop, w_drop;
  logic                 r_ovf;

  // D=0 behaves like D=1; '>=' lets a shrinking D wrap at once instead of running to overflow.
  assign w_dec_m1 = (Dec_DI == '0) ? '0 : Dec_DI - DEC_WIDTH'(1);
  assign w_keep   = NYQ_Vld_SI && (r_phase == '0);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI)          r_phase <= '0;
    else if (Clr_SI)     r_phase <= '0;
    else if (NYQ_Vld_SI) r_phase <= (r_phase >= w_dec_m1) ? '0 : r_phase + DEC_WIDTH'(1);
  end

  // Sign-extend by one bit so the half-LSB add cannot wrap; only positive overflow results.
  assign w_sum = {NYQ_In_DI[IN_WIDTH-1], NYQ_In_DI} + L_HALF;
  assign w_shr = w_sum[IN_WIDTH:S];

`ifdef NYQ_DEC_SAT_EN
  assign w_rnd    = (!w_shr[OUT_WIDTH] && w_shr[OUT_WIDTH-1]) ? L_SAT_MAX : w_shr[OUT_WIDTH-1:0];
  assign w_unused = ^w_sum[S-1:0];
`else
  assign w_rnd    = w_shr[OUT_WIDTH-1:0];
  assign w_unused = ^{w_sum[S-1:0], w_shr[OUT_WIDTH]};
`endif

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_s1_vld <= 1'b0;
      r_s1_dat <= '0;
    end else begin
      r_s1_vld <= w_keep && !Clr_SI;
      if (w_keep) r_s1_dat <= w_rnd;
    end
  end

  assign w_pop  = !w_empty && Dec_Rdy_SI;
  assign w_drop = r_s1_vld && w_full && !w_pop;

  nyq_dec_fifo #(.W(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk_CI  (Clk_CI),
    .Rst_RI  (Rst_RI),
    .i_clr   (Clr_SI),
    .i_push  (r_s1_vld),
    .i_data  (r_s1_dat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (Fill_DO)
  );

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI)      r_ovf <= 1'b0;
    else if (Clr_SI) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  // Remember the head so the output holds its last value once the FIFO drains.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI)        r_hold <= '0;
    else if (!w_empty) r_hold <= w_head;
  end

  assign Dec_Out_DO = w_empty ? r_hold : w_head;
  assign Dec_Vld_SO = !w_empty;
  assign Ovf_SO     = r_ovf;

endmodule
